// File: rtl/fp_mac_issue_ctrl.sv
// Issue sequencer for one fp_mac lane: operand FIFO, three-phase enable
// sequencing, mac_val wait with timeout, and a one-entry result register.
module fp_mac_issue_ctrl #(
    parameter int FIFO_DEPTH  = 4,
    parameter int VAL_TIMEOUT = 15
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [15:0]                   in_a,
    input  logic [15:0]                   in_b,
    input  logic [15:0]                   in_add,
    output logic [15:0]                   opA,
    output logic [15:0]                   opB,
    output logic [15:0]                   opADD,
    output logic                          enA,
    output logic                          enB,
    output logic                          enADD,
    output logic                          en_Mul_A,
    output logic                          en_Mul_B,
    output logic                          en_Add_A,
    output logic                          en_Add_B,
    input  logic [15:0]                   mac_out,
    input  logic                          mac_val,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [15:0]                   res_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy,
    output logic                          err_timeout,
    output logic [15:0]                   done_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(VAL_TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MUL, S_ADD, S_CAPT} state_t;

    state_t            r_state;
    logic [47:0]       r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic [15:0]       r_opA;
    logic [15:0]       r_opB;
    logic [15:0]       r_opADD;
    logic              r_en_load;
    logic              r_en_mul;
    logic              r_en_add;
    logic [TW-1:0]     r_tmo;
    logic              r_err;
    logic              r_res_valid;
    logic [15:0]       r_res_data;
    logic [15:0]       r_done;

    logic              w_in_ready;
    logic              w_nonempty;
    logic              w_res_free;
    logic              w_capture;
    logic              w_push;
    logic              w_pop;
    logic [47:0]       w_head;

    assign w_in_ready = (r_count != (AW+1)'(FIFO_DEPTH));
    assign w_nonempty = (r_count != '0);
    assign w_res_free = !r_res_valid || res_ready;
    assign w_capture  = (r_state == S_CAPT) && mac_val && w_res_free;
    assign w_push     = in_valid && w_in_ready;
    // Pop either when idle or when a capture frees the lane for back-to-back issue.
    assign w_pop      = w_nonempty && ((r_state == S_IDLE) || w_capture);
    assign w_head     = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {in_a, in_b, in_add};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_opA       <= '0;
            r_opB       <= '0;
            r_opADD     <= '0;
            r_en_load   <= 1'b0;
            r_en_mul    <= 1'b0;
            r_en_add    <= 1'b0;
            r_tmo       <= '0;
            r_err       <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_done      <= '0;
        end else begin
            if (res_ready) r_res_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_nonempty) begin
                        r_state                  <= S_LOAD;
                        {r_opA, r_opB, r_opADD}  <= w_head;
                        r_en_load                <= 1'b1;
                    end
                end
                S_LOAD: begin
                    r_state   <= S_MUL;
                    r_en_load <= 1'b0;
                    r_en_mul  <= 1'b1;
                end
                S_MUL: begin
                    r_state  <= S_ADD;
                    r_en_mul <= 1'b0;
                    r_en_add <= 1'b1;
                end
                S_ADD: begin
                    r_state  <= S_CAPT;
                    r_en_add <= 1'b0;
                    r_tmo    <= '0;
                end
                S_CAPT: begin
                    // mac_val with a full, undrained result register is a stall, not a timeout tick.
                    if (mac_val) begin
                        if (w_res_free) begin
                            r_res_data  <= mac_out;
                            r_res_valid <= 1'b1;
                            r_done      <= r_done + 16'd1;
                            if (w_nonempty) begin
                                r_state                 <= S_LOAD;
                                {r_opA, r_opB, r_opADD} <= w_head;
                                r_en_load               <= 1'b1;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end
                    end else if (r_tmo == TW'(VAL_TIMEOUT - 1)) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready    = w_in_ready;
    assign opA         = r_opA;
    assign opB         = r_opB;
    assign opADD       = r_opADD;
    assign enA         = r_en_load;
    assign enB         = r_en_load;
    assign enADD       = r_en_load;
    assign en_Mul_A    = r_en_mul;
    assign en_Mul_B    = r_en_mul;
    assign en_Add_A    = r_en_add;
    assign en_Add_B    = r_en_add;
    assign res_valid   = r_res_valid;
    assign res_data    = r_res_data;
    assign fifo_count  = r_count;
    assign busy        = (r_state != S_IDLE) || w_nonempty || r_res_valid;
    assign err_timeout = r_err;
    assign done_cnt    = r_done;
endmodule

// File: doc/fp_mac_issue_ctrl.md
Name: fp_mac_issue_ctrl

Overview:
Upstream sequencer for one fp_mac lane in the FP16 systolic row.
- Input side: queues (A, B, ADD) operand triples from a valid/ready stream in a small FIFO.
- MAC side: drives the fp_mac three-phase enable sequence (operand load, MUL capture, ADD capture), then waits for fp_mac val_o.
- Output side: captures out_o into a one-entry result register with a valid/ready output.
- Replaces hand-sequenced enables, so back-to-back issue needs no software timing.

Parameters:
FIFO_DEPTH, 4, operand FIFO entries; power of 2, >=2
VAL_TIMEOUT, 15, max CAPT cycles waiting for mac_val before abort; >=1

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  operand triple valid
in_ready  out  1  FIFO can accept
in_a  in  16  FP16 multiplicand
in_b  in  16  FP16 multiplier
in_add  in  16  FP16 addend
opA  out  16  to fp_mac opA
opB  out  16  to fp_mac opB
opADD  out  16  to fp_mac opADD
enA  out  1  to fp_mac enA
enB  out  1  to fp_mac enB
enADD  out  1  to fp_mac enADD
en_Mul_A  out  1  to fp_mac en_Mul_A
en_Mul_B  out  1  to fp_mac en_Mul_B
en_Add_A  out  1  to fp_mac en_Add_A
en_Add_B  out  1  to fp_mac en_Add_B
mac_out  in  16  from fp_mac out_o
mac_val  in  1  from fp_mac val_o
res_valid  out  1  result valid
res_ready  in  1  downstream accepts result
res_data  out  16  FP16 result
fifo_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
busy  out  1  work pending
err_timeout  out  1  sticky mac_val timeout flag
done_cnt  out  16  completed-op counter

Behaviour:
- Reset (async, rst=1): state IDLE, FIFO empty. opA/opB/opADD, all enables, res_valid, res_data, err_timeout, done_cnt, timeout counter = 0. Effect is immediate, including mid-operation; in-flight and queued ops are discarded.
- in_ready = (fifo_count != FIFO_DEPTH), decoded from registered count; reads 1 after reset.
- Push on in_valid & in_ready. No fall-through: a triple pushed at edge t is poppable from edge t+1.
- Pop only when count > 0. Push and pop in the same cycle leave count unchanged.
- FSM states: IDLE, LOAD, MUL, ADD, CAPT. Enables are Moore decodes of the state register:
  - LOAD: enA = enB = enADD = 1.
  - MUL: en_Mul_A = en_Mul_B = 1.
  - ADD: en_Add_A = en_Add_B = 1.
  - All other enables 0 in every other state.
- IDLE -> LOAD when count > 0. The FIFO head is popped into the opA/opB/opADD registers on that edge. The op registers hold their value until the next pop.
- LOAD -> MUL -> ADD -> CAPT unconditionally, one cycle each. The timeout counter clears on entry to CAPT.
- CAPT, mac_val=1 and (!res_valid | res_ready):
  - res_data <= mac_out, res_valid <= 1, done_cnt++ (wraps FFFF -> 0).
  - Next state is LOAD with pop if count > 0, else IDLE.
- CAPT, mac_val=1 with result register full and not draining: stall in CAPT. Enables stay 0; mac_out is held stable by fp_mac. Stall cycles do not count toward timeout.
- CAPT, mac_val=0: timeout counter++. When it reaches VAL_TIMEOUT: err_timeout <= 1 (sticky until rst), op dropped, no result, done_cnt unchanged, then go to IDLE.
- Result register: res_valid clears on res_ready unless a capture occurs the same cycle. Capture plus drain in one cycle leaves res_valid = 1 with the new data.
- Throughput: one op per 4 cycles minimum (LOAD..CAPT with immediate mac_val).
- busy = (state != IDLE) | (fifo_count != 0) | res_valid.

Test Plan:
1. Reset, push {4000, 4200, 3800} (2.0×3.0+0.5), fp_mac model asserts mac_val in CAPT -> enA/enB/enADD high exactly 1 cycle after pop, en_Mul 1 cycle later, en_Add 1 cycle later; res_data = 16'h4680, res_valid = 1, done_cnt = 1.
2. Push 4 triples back-to-back, res_ready = 1, including {3C00, 4000, 4200} -> LOAD every 4 cycles; that result = 16'h4500; done_cnt = 4; busy falls after last drain.
3. FIFO_DEPTH = 4, res_ready held 0, in_valid held 1 -> exactly 6 triples accepted (1 in result register, 1 stalled in CAPT, 4 queued) before in_ready = 0 and fifo_count = 4; raise res_ready -> all drain in order.
4. Model never asserts mac_val -> err_timeout rises after 15 CAPT cycles; FSM in IDLE; res_valid = 0; next queued op still processes normally with err_timeout staying 1.
5. Assert rst during MUL with 2 ops queued -> en_Mul_A/B drop same cycle (asynchronous); fifo_count = 0, res_valid = 0, done_cnt = 0, in_ready = 1.
6. res_valid = 1 and res_ready = 1 in the same cycle a CAPT capture occurs -> res_valid stays 1, res_data updates to the new value, no result lost or duplicated.
